vga_frame_gen: RTL

Parametrised video timing and frame-source generator for the HDMI output path; generalises the fixed 640x480 timing and image-fetch logic into one block. It generates hsync/vsync/de for any parameter-defined video mode and fetches an IMG_W x IMG_H 8-bit greyscale image from an external synchronous RAM with configurable read latency. It places the image at a programmable window offset and offers test-pattern modes. Outputs feed the TMDS encoder stage directly, with rgb, de and syncs cycle-aligned.

---
 rtl/vga_frame_gen.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/vga_frame_gen.sv
// vga_frame_gen: parametrised video timing generator with windowed RAM image fetch and test patterns
module vga_frame_gen #(
    parameter int          H_SYNC   = 96,
    parameter int          H_BACK   = 48,
    parameter int          H_ACTIVE = 640,
    parameter int          H_FRONT  = 16,
    parameter int          V_SYNC   = 2,
    parameter int          V_BACK   = 33,
    parameter int          V_ACTIVE = 480,
    parameter int          V_FRONT  = 10,
    parameter logic        HS_POL   = 1'b0,
    parameter logic        VS_POL   = 1'b0,
    parameter int          IMG_W    = 256,
    parameter int          IMG_H    = 256,
    parameter int          IMG_X0   = 192,
    parameter int          IMG_Y0   = 112,
    parameter int          RD_LAT   = 1,
    parameter int          ADDR_W   = 16,
    parameter logic [23:0] BG_COLOR = 24'h000080
) (
    input  logic              vga_clk,
    input  logic              sys_rst_n,
    input  logic [1:0]        mode,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic              hsync,
    output logic              vsync,
    output logic              de,
    output logic [23:0]       rgb,
    output logic [9:0]        pix_x,
    output logic [9:0]        pix_y,
    output logic              frame_start
);
    localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
    localparam int HW = $clog2(H_TOTAL + 1);
    localparam int VW = $clog2(V_TOTAL + 1);
    localparam int BAR_W = H_ACTIVE / 8;
    localparam int BW = BAR_W > 1 ? $clog2(BAR_W) : 1;
    localparam logic [HW-1:0] HS1 = HW'(H_SYNC);
    localparam logic [HW-1:0] HA0 = HW'(H_SYNC + H_BACK);
    localparam logic [HW-1:0] HA1 = HW'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [HW-1:0] HX0 = HW'(H_SYNC + H_BACK + IMG_X0);
    localparam logic [HW-1:0] HX1 = HW'(H_SYNC + H_BACK + IMG_X0 + IMG_W);
    localparam logic [HW-1:0] HL  = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] VS1 = VW'(V_SYNC);
    localparam logic [VW-1:0] VA0 = VW'(V_SYNC + V_BACK);
    localparam logic [VW-1:0] VA1 = VW'(V_SYNC + V_BACK + V_ACTIVE);
    localparam logic [VW-1:0] VY0 = VW'(V_SYNC + V_BACK + IMG_Y0);
    localparam logic [VW-1:0] VY1 = VW'(V_SYNC + V_BACK + IMG_Y0 + IMG_H);
    localparam logic [VW-1:0] VL  = VW'(V_TOTAL - 1);
    localparam logic [BW-1:0] BL  = BW'(BAR_W - 1);

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       de;
        logic       win;
        logic       fs;
        logic [1:0] mode;
        logic [2:0] bar;
        logic [9:0] x;
        logic [9:0] y;
    } dec_t;

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic [1:0]    mode_r;
    logic [BW-1:0] bar_sub;
    logic [2:0]    bar_idx;
    logic          h_act, v_act, act, win, frame0, h_last, v_last;
    dec_t          s0, q;
    dec_t          dl [RD_LAT];
    logic [23:0]   pix;

    always_comb begin
        h_act  = h_cnt >= HA0 && h_cnt < HA1;
        v_act  = v_cnt >= VA0 && v_cnt < VA1;
        act    = h_act && v_act;
        win    = h_cnt >= HX0 && h_cnt < HX1 && v_cnt >= VY0 && v_cnt < VY1;
        frame0 = h_cnt == '0 && v_cnt == '0;
        h_last = h_cnt == HL;
        v_last = v_cnt == VL;
        rd_en  = mode_r == 2'b00 && win;
        s0.hs   = h_cnt < HS1;
        s0.vs   = v_cnt < VS1;
        s0.de   = act;
        s0.win  = win;
        s0.fs   = frame0;
        s0.mode = mode_r;
        s0.bar  = bar_idx;
        s0.x    = act ? 10'(h_cnt - HA0) : '0;
        s0.y    = act ? 10'(v_cnt - VA0) : '0;
    end

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            h_cnt   <= '0;
            v_cnt   <= '0;
            mode_r  <= 2'b00;
            rd_addr <= '0;
            bar_sub <= '0;
            bar_idx <= '0;
            for (int i = 0; i < RD_LAT; i++) dl[i] <= '0;
        end else begin
            h_cnt <= h_last ? '0 : h_cnt + 1'b1;
            if (h_last) v_cnt <= v_last ? '0 : v_cnt + 1'b1;
            if (frame0) mode_r <= mode;
            rd_addr <= frame0 ? '0 : rd_en ? rd_addr + 1'b1 : rd_addr;
            bar_sub <= !h_act || bar_sub == BL ? '0 : bar_sub + 1'b1;
            bar_idx <= !h_act ? '0 : bar_sub == BL ? bar_idx + 1'b1 : bar_idx;
            dl[0] <= s0;
            for (int i = 1; i < RD_LAT; i++) dl[i] <= dl[i-1];
        end
    end

    always_comb begin
        q   = dl[RD_LAT-1];
        pix = q.mode == 2'd0 ? (q.win ? {3{rd_data}} : BG_COLOR) :
              q.mode == 2'd1 ? {{8{~q.bar[1]}}, {8{~q.bar[2]}}, {8{~q.bar[0]}}} :
              q.mode == 2'd2 ? {3{q.x[7:0]}} : 24'hFFFFFF;
    end

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            de          <= 1'b0;
            rgb         <= '0;
            pix_x       <= '0;
            pix_y       <= '0;
            frame_start <= 1'b0;
        end else begin
            hsync       <= q.hs ? HS_POL : ~HS_POL;
            vsync       <= q.vs ? VS_POL : ~VS_POL;
            de          <= q.de;
            rgb         <= q.de ? pix : '0;
            pix_x       <= q.x;
            pix_y       <= q.y;
            frame_start <= q.fs;
        end
    end
endmodule
